commit_trace_buffer: RTL
========================

Name: commit_trace_buffer

Overview:
- Consumer side of the processor's per-cycle commit trace: PC, INSTRUCTION, ALU_OUT, RD_DATA_WRITE_BACK.
- Captures one 4-word record per valid commit into a record FIFO.
- Streams records out one 32-bit word at a time over a valid/ready read port, for a debug/UART/host drain.
- Sits beside the RISCV_PROCESSOR top, fed directly from its trace outputs.

Parameters:
- DEPTH, 16, number of 128-bit records held; power of two, at least 2.
- ADDR_WIDTH, 4, log2(DEPTH).
- DATA_WIDTH, 32, width of each trace field and of RD_DATA.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  capture enable; TRACE_VALID is ignored while low.
- TRACE_VALID  in  1  the current cycle's trace fields are a committed instruction.
- PC  in  32  committed PC.
- INSTRUCTION  in  32  committed instruction word.
- ALU_OUT  in  32  ALU result.
- RD_DATA_WRITE_BACK  in  32  write-back data.
- RD_READY  in  1  drain side accepts the current word.
- RD_VALID  out  1  RD_DATA holds a valid word.
- RD_DATA  out  32  current output word.
- RD_LAST  out  1  current word is word 3 of its record.
- COUNT  out  ADDR_WIDTH+1  records stored, including the one being drained.
- OVERFLOW  out  1  sticky: at least one record dropped because the FIFO was full.
- CLEAR_OVERFLOW  in  1  clears OVERFLOW.

Behaviour:
- Reset values (RST high at a clock edge):
  - RD_VALID=0, RD_DATA=0, RD_LAST=0, COUNT=0, OVERFLOW=0.
  - Word index=W0; FIFO pointers=0.
  - A record mid-drain is discarded; no partial words appear after reset.
- Push:
  - push_req = ENABLE & TRACE_VALID.
  - The record {WB, ALU_OUT, INSTRUCTION, PC} (PC in bits 31:0) is written on the edge when push_req is high and the FIFO is not full.
- Full:
  - push_req while full drops the record and sets OVERFLOW on that edge; FIFO contents are unchanged.
- Read FSM, 2-bit word index W0 to W1 to W2 to W3 to W0:
  - W0 presents PC, W1 INSTRUCTION, W2 ALU_OUT, W3 RD_DATA_WRITE_BACK.
  - RD_DATA is driven from the FIFO head and the word index.
  - RD_LAST = (index==W3) & RD_VALID.
- Handshake:
  - RD_VALID = FIFO not empty.
  - A word transfers on an edge with RD_VALID & RD_READY; the index then advances.
  - A transfer at W3 pops the head and returns the index to W0.
  - While RD_VALID & !RD_READY, RD_DATA, RD_LAST and the index hold stable.
  - RD_READY while RD_VALID=0 has no effect.
- Latency: a push into an empty FIFO raises RD_VALID on the cycle after the push edge (1 cycle), with PC presented.
- Simultaneous push and W3 pop:
  - Both take effect; COUNT is unchanged.
  - When the FIFO is full, the pop frees the slot in the same cycle, so the push is accepted with no drop and OVERFLOW is not set.
- OVERFLOW clear:
  - CLEAR_OVERFLOW clears OVERFLOW.
  - If CLEAR_OVERFLOW and a drop occur on the same edge, the set wins (OVERFLOW=1).
- Wrap-around:
  - Pointers are ADDR_WIDTH+1 bits with a wrap bit.
  - full = addresses equal and wrap bits differ; empty = pointers equal.
  - COUNT = wr_ptr - rd_ptr (modulo arithmetic).
- ENABLE low does not stall draining.
- X on trace fields with TRACE_VALID=0 must not propagate into state.

Decomposition:
- Package trace_pkg:
  - TRACE_WORD_W=32, TRACE_REC_W=128.
  - Word-index encodings W0..W3.
  - Field bit offsets within a record.
- Sub-module trace_record_fifo:
  - Synchronous single-clock FIFO, TRACE_REC_W wide, DEPTH deep.
  - Exposes push, pop, full, empty, count, and a head output.
- The top holds the word-index FSM, the output mux and OVERFLOW.

Test Plan:
- Single record: push PC=0x00000000, INSTR=0x00500093, ALU=0x5, WB=0x5 with RD_READY=1 → RD_VALID the next cycle; words 0x0, 0x00500093, 0x5, 0x5 on consecutive cycles; RD_LAST only on the 4th; COUNT 1→0.
- Backpressure: RD_READY=0 for 5 cycles at W1 → RD_DATA holds 0x00500093 and the index stays W1; release → W2 word 0x5 on the following edge.
- Fill and overflow: 16 pushes with no drain → COUNT=16; 17th push (PC=0x40) → dropped, OVERFLOW=1, COUNT=16; drain → 16 records with PC 0x0..0x3C in order.
- Full with a simultaneous pop at W3 plus push → COUNT stays 16, OVERFLOW stays 0, new record appears last.
- Reset mid-drain: RST at W2 with 3 records queued → next cycle RD_VALID=0, COUNT=0, OVERFLOW=0; a new push then streams from W0.
- ENABLE=0 with TRACE_VALID=1 for 4 cycles → COUNT stays 0; CLEAR_OVERFLOW in the same cycle as a drop → OVERFLOW=1.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared widths, word-index encodings and record field offsets for the commit trace buffer.
package trace_pkg;

  localparam int TRACE_WORD_W = 32;
  localparam int TRACE_REC_W  = 128;

  // Record layout: {WB, ALU_OUT, INSTRUCTION, PC}, PC in the low word.
  localparam int PC_LSB    = 0;
  localparam int INSTR_LSB = 32;
  localparam int ALU_LSB   = 64;
  localparam int WB_LSB    = 96;

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2,
    W3 = 2'd3
  } word_idx_e;

endpackage

// File: rtl/trace_record_fifo.sv
// Single-clock record FIFO with wrap-bit pointers; a pop while full frees the slot for a same-edge push.
module trace_record_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [TRACE_REC_W-1:0] din,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_WIDTH:0]    count,
  output logic [TRACE_REC_W-1:0] head
);

  logic [TRACE_REC_W-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]    wr_ptr;
  logic [ADDR_WIDTH:0]    rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[ADDR_WIDTH-1:0]];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only accepted pushes ever write it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures per-commit trace records and drains them one 32-bit word at a time over valid/ready.
//   state | meaning
//   W0    | presenting PC of head record
//   W1    | presenting INSTRUCTION
//   W2    | presenting ALU_OUT
//   W3    | presenting write-back data; transfer pops the record
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic                  TRACE_VALID,
  input  logic [DATA_WIDTH-1:0] PC,
  input  logic [DATA_WIDTH-1:0] INSTRUCTION,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic [DATA_WIDTH-1:0] RD_DATA_WRITE_BACK,
  input  logic                  RD_READY,
  output logic                  RD_VALID,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_LAST,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  input  logic                  CLEAR_OVERFLOW
);

  logic                   push_req;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   full;
  logic                   empty;
  logic                   xfer;
  logic                   drop;
  logic [TRACE_REC_W-1:0] rec_in;
  logic [TRACE_REC_W-1:0] head;
  word_idx_e              idx_q;
  word_idx_e              idx_d;

  assign push_req = ENABLE & TRACE_VALID;
  assign rec_in   = {RD_DATA_WRITE_BACK, ALU_OUT, INSTRUCTION, PC};
  assign RD_VALID = ~empty;
  assign xfer     = RD_VALID & RD_READY;
  assign fifo_pop = xfer & (idx_q == W3);
  // A W3 pop on the same edge makes room, so only a push without it is dropped.
  assign drop      = push_req & full & ~fifo_pop;
  assign fifo_push = push_req & ~drop;

  trace_record_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (fifo_push),
    .din   (rec_in),
    .pop   (fifo_pop),
    .full  (full),
    .empty (empty),
    .count (COUNT),
    .head  (head)
  );

  always_ff @(posedge CLK) begin
    if (RST) idx_q <= W0;
    else     idx_q <= idx_d;
  end

  always_comb begin
    idx_d   = idx_q;
    RD_DATA = '0;
    RD_LAST = 1'b0;
    if (xfer) idx_d = word_idx_e'(idx_q + 2'd1);
    if (RD_VALID) begin
      RD_LAST = (idx_q == W3);
      case (idx_q)
        W0:      RD_DATA = head[PC_LSB    +: TRACE_WORD_W];
        W1:      RD_DATA = head[INSTR_LSB +: TRACE_WORD_W];
        W2:      RD_DATA = head[ALU_LSB   +: TRACE_WORD_W];
        default: RD_DATA = head[WB_LSB    +: TRACE_WORD_W];
      endcase
    end
  end

  // A drop and a clear on the same edge leave the flag set.
  always_ff @(posedge CLK) begin
    if (RST)                 OVERFLOW <= 1'b0;
    else if (drop)           OVERFLOW <= 1'b1;
    else if (CLEAR_OVERFLOW) OVERFLOW <= 1'b0;
  end

endmodule
